id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of the ALU; it captures decoded operands and drives the ALU d0/d1/ALUctrl.
//  Valid/ready handshake with one register slot, flush from branch resolution, and EX/MEM then MEM/WB operand forwarding.
//  While the slot is held, the captured operands are refreshed from the forwarding buses every cycle.
// PARAMETERS
//  WIDTH   32  datapath width of operands, immediate and results
//  RADDR   5   register-address width
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  flush          in   1      kill held and incoming instruction
//  in_valid       in   1      decode presents an instruction
//  in_ready       out  1      stage can accept this cycle
//  rs1_addr       in   RADDR  source 1 register index
//  rs2_addr       in   RADDR  source 2 register index
//  rd_addr        in   RADDR  destination register index
//  rs1_data       in   WIDTH  register-file read data 1
//  rs2_data       in   WIDTH  register-file read data 2
//  imm            in   WIDTH  sign-extended immediate
//  alu_src        in   1      1: d1 = imm; 0: d1 = rs2 value
//  alu_ctrl_in    in   3      ALU operation code
//  reg_write_in   in   1      instruction writes rd
//  exm_reg_write  in   1      EX/MEM stage writes exm_rd
//  exm_rd         in   RADDR  EX/MEM destination register
//  exm_result     in   WIDTH  EX/MEM result
//  wb_reg_write   in   1      MEM/WB stage writes wb_rd
//  wb_rd          in   RADDR  MEM/WB destination register
//  wb_result      in   WIDTH  MEM/WB result
//  out_valid      out  1      d0/d1/ALUctrl hold a live instruction
//  out_ready      in   1      the EX stage consumes this cycle
//  d0, d1         out  WIDTH  ALU operands (registered)
//  ALUctrl        out  3      ALU operation code (registered)
//  rd_out         out  RADDR  destination register passed down the pipe
//  reg_write_out  out  1      write-enable passed down the pipe
// BEHAVIOUR
//  Reset: async clear while rst_n=0; out_valid=0, d0=d1=0, ALUctrl=3'b000, rd_out=0, reg_write_out=0, held addresses=0.
//  Handshake: in_ready = ~out_valid | out_ready (combinational); accept = in_valid & in_ready; latency is 1 cycle.
//  Accept and consume in the same cycle: the new instruction replaces the old one; no bubble.
//  Held (out_valid & ~out_ready): outputs are stable except for forwarding refresh.
//  Forward select per source: EX/MEM when exm_reg_write & exm_rd==addr & addr!=0; otherwise MEM/WB on the same rule; otherwise rf data.
//  EX/MEM has priority when both sources match; register x0 is never forwarded.
//  The held rs1/rs2 addresses are re-evaluated every held cycle, and a match overwrites d0 (or d1 when alu_src=0).
//  The immediate operand is never overwritten.
//  ALU codes: 000, 001, 010, 011 and 101 are stored unchanged; 100, 110 and 111 are stored as 000 (ADD).
//  reg_write_out is forced to 0 when rd_addr==0.
//  flush: next cycle out_valid=0 and reg_write_out=0; flush beats a simultaneous accept, and data fields keep their old values.
//  The held forward refresh is the only update to a live slot without a new accept.
// CONFIGURATION
//  ID_EX_FWD_EN defined: forwarding and the held refresh are as above.
//  ID_EX_FWD_EN undefined: d0 = rs1_data, d1 = alu_src ? imm : rs2_data, captured on accept only.
//  Without the macro, the exm_* and wb_* ports remain present but are ignored.
// STRUCTURE
//  riscv_pkg holds alu_op_e (ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, SLT=3'b101), WIDTH_DEF=32 and RADDR_DEF=5.
//  Sub-module operand_fwd: a combinational 3-way forward-select mux, instantiated twice (rs1, rs2).
// TESTING
//  1. Reset: hold rst_n=0 mid-transfer -> all outputs 0 immediately; in_ready=1 after release.
//  2. Accept rs1_data=5, imm=7, alu_src=1, alu_ctrl_in=000 -> next cycle d0=5, d1=7, out_valid=1.
//  3. rs1_addr=3 with exm_rd=3 (exm_result=0xAA) and wb_rd=3 (wb_result=0xBB) -> d0=0xAA; with rd=0 at the source -> rf data.
//  4. Hold with out_ready=0 for 3 cycles, EX/MEM writes rs2's reg with 0x42 in cycle 2, alu_src=0 -> d1=0x42 from cycle 3, ALUctrl unchanged.
//  5. flush together with in_valid=1 -> out_valid=0 next cycle; the instruction is dropped and reg_write_out=0.
//  6. alu_ctrl_in=3'b110 -> ALUctrl=3'b000; rd_addr=0 with reg_write_in=1 -> reg_write_out=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the ID/EX stage: ALU opcodes, widths, opcode legalisation.
package riscv_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned RADDR_DEF = 5;
  localparam int unsigned ALU_W     = 3;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  // Unsupported opcodes collapse to ADD so the ALU only ever sees a known operation
  function automatic logic [ALU_W-1:0] alu_legalize(input logic [ALU_W-1:0] code);
    case (code)
      ALU_SUB: return ALU_SUB;
      ALU_AND: return ALU_AND;
      ALU_OR:  return ALU_OR;
      ALU_SLT: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-ALU bus: valid/ready handshake, decoded operands in, ALU operands out.
interface id_ex_stage_if
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RADDR = RADDR_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [RADDR-1:0] rs1_addr;
  logic [RADDR-1:0] rs2_addr;
  logic [RADDR-1:0] rd_addr;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [WIDTH-1:0] imm;
  logic             alu_src;
  logic [ALU_W-1:0] alu_ctrl_in;
  logic             reg_write_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [ALU_W-1:0] ALUctrl;
  logic [RADDR-1:0] rd_out;
  logic             reg_write_out;

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm,
           alu_src, alu_ctrl_in, reg_write_in, out_ready,
    output in_ready, out_valid, d0, d1, ALUctrl, rd_out, reg_write_out
  );

  modport master (
    output in_valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm,
           alu_src, alu_ctrl_in, reg_write_in, out_ready,
    input  in_ready, out_valid, d0, d1, ALUctrl, rd_out, reg_write_out
  );
endinterface

// File: rtl/operand_fwd.sv
// Three-way operand source select: EX/MEM result, MEM/WB result, or register-file data.
module operand_fwd
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RADDR = RADDR_DEF
) (
  input  logic [RADDR-1:0] addr,
  input  logic [WIDTH-1:0] rf_data,
  input  logic             exm_reg_write,
  input  logic [RADDR-1:0] exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             wb_reg_write,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] data_c,
  output logic             hit_c
);

  // Younger EX/MEM result wins; x0 is hard-wired and never forwarded
  always_comb begin
    data_c = rf_data;
    hit_c  = 1'b0;
    if (addr != '0) begin
      if (exm_reg_write && (exm_rd == addr)) begin
        data_c = exm_result;
        hit_c  = 1'b1;
      end else if (wb_reg_write && (wb_rd == addr)) begin
        data_c = wb_result;
        hit_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with flush and EX/MEM, MEM/WB forwarding.
// Forwarding and the held-slot refresh exist only when ID_EX_FWD_EN is defined.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RADDR = RADDR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  id_ex_stage_if.slave     bus,
  input  logic             exm_reg_write,
  input  logic [RADDR-1:0] exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             wb_reg_write,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_result
);

`ifdef ID_EX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
  logic unused_c;
  assign unused_c = ^{exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result};
`endif

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] d0_q, d0_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [ALU_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic             reg_write_q, reg_write_d;
  logic [RADDR-1:0] rs1_addr_q, rs1_addr_d;
  logic [RADDR-1:0] rs2_addr_q, rs2_addr_d;
  logic             alu_src_q, alu_src_d;

  logic             hold_c;
  logic             accept_c;
  logic [RADDR-1:0] fwd1_addr_c, fwd2_addr_c;
  logic [WIDTH-1:0] fwd1_data_c, fwd2_data_c;
  logic             fwd1_hit_c, fwd2_hit_c;
  logic             exm_we_c, wb_we_c;

  assign hold_c       = valid_q & ~bus.out_ready;
  assign bus.in_ready = ~valid_q | bus.out_ready;
  assign accept_c     = bus.in_valid & bus.in_ready;
  assign exm_we_c     = exm_reg_write & FWD_EN;
  assign wb_we_c      = wb_reg_write & FWD_EN;

  // A held slot re-resolves its own source registers; otherwise resolve the incoming ones
  assign fwd1_addr_c = hold_c ? rs1_addr_q : bus.rs1_addr;
  assign fwd2_addr_c = hold_c ? rs2_addr_q : bus.rs2_addr;

  operand_fwd #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs1 (
    .addr(fwd1_addr_c), .rf_data(bus.rs1_data),
    .exm_reg_write(exm_we_c), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_we_c), .wb_rd(wb_rd), .wb_result(wb_result),
    .data_c(fwd1_data_c), .hit_c(fwd1_hit_c)
  );

  operand_fwd #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs2 (
    .addr(fwd2_addr_c), .rf_data(bus.rs2_data),
    .exm_reg_write(exm_we_c), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_we_c), .wb_rd(wb_rd), .wb_result(wb_result),
    .data_c(fwd2_data_c), .hit_c(fwd2_hit_c)
  );

  // Flush kills control only; data fields keep their last values
  always_comb begin
    valid_d     = valid_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    alu_ctrl_d  = alu_ctrl_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    alu_src_d   = alu_src_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (accept_c) begin
      valid_d     = 1'b1;
      d0_d        = fwd1_data_c;
      d1_d        = bus.alu_src ? bus.imm : fwd2_data_c;
      alu_ctrl_d  = alu_legalize(bus.alu_ctrl_in);
      rd_d        = bus.rd_addr;
      reg_write_d = bus.reg_write_in & (bus.rd_addr != '0);
      rs1_addr_d  = bus.rs1_addr;
      rs2_addr_d  = bus.rs2_addr;
      alu_src_d   = bus.alu_src;
    end else if (hold_c) begin
      if (fwd1_hit_c) d0_d = fwd1_data_c;
      if (!alu_src_q && fwd2_hit_c) d1_d = fwd2_data_c;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
      alu_ctrl_q  <= ALU_ADD;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      alu_src_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      alu_src_q   <= alu_src_d;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.d0            = d0_q;
  assign bus.d1            = d1_q;
  assign bus.ALUctrl       = alu_ctrl_q;
  assign bus.rd_out        = rd_q;
  assign bus.reg_write_out = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FWD_EN when defined.
module tb_id_ex_stage;
  import riscv_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  int          checks;
  int          errors;

  id_ex_stage_if #(.WIDTH(32), .RADDR(5)) bus ();

  id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; flush = 1'b0;
    bus.rs1_addr = '0; bus.rs2_addr = '0; bus.rd_addr = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.imm = '0;
    bus.alu_src = 1'b0; bus.alu_ctrl_in = 3'b000; bus.reg_write_in = 1'b0;
    exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.in_valid = 1'b1; bus.rs1_data = 32'h9; bus.imm = 32'h3; bus.alu_src = 1'b1;
    bus.rd_addr = 5'd4; bus.reg_write_in = 1'b1; bus.alu_ctrl_in = 3'b001;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.d0, bus.d1, bus.ALUctrl, bus.rd_out, bus.reg_write_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d0=%h d1=%h ctrl=%b rd=%0d rw=%b want all 0",
               bus.out_valid, bus.d0, bus.d1, bus.ALUctrl, bus.rd_out, bus.reg_write_out);
    end
    idle_inputs();
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_accept();
    idle_inputs();
    bus.in_valid = 1'b1; bus.rs1_data = 32'd5; bus.imm = 32'd7; bus.alu_src = 1'b1;
    bus.rs2_data = 32'hDEAD; bus.alu_ctrl_in = 3'b000; bus.rd_addr = 5'd1; bus.reg_write_in = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL accept_valid: got %b want 1", bus.out_valid); end
    checks++;
    if (bus.d0 !== 32'd5) begin errors++; $display("FAIL accept_d0: got %h want 5", bus.d0); end
    checks++;
    if (bus.d1 !== 32'd7) begin errors++; $display("FAIL accept_d1: got %h want 7", bus.d1); end
    checks++;
    if (bus.rd_out !== 5'd1 || bus.reg_write_out !== 1'b1) begin
      errors++; $display("FAIL accept_rd: got rd=%0d rw=%b want rd=1 rw=1", bus.rd_out, bus.reg_write_out);
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL consume_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_forward();
    idle_inputs();
    bus.in_valid = 1'b1; bus.rs1_addr = 5'd3; bus.rs1_data = 32'h11; bus.alu_src = 1'b1;
    exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'hAA;
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
    tick();
    checks++;
    if (bus.d0 !== (FWD ? 32'hAA : 32'h11)) begin errors++; $display("FAIL fwd_exm_priority: got %h want %h", bus.d0, FWD ? 32'hAA : 32'h11); end
    exm_reg_write = 1'b0;
    tick();
    checks++;
    if (bus.d0 !== (FWD ? 32'hBB : 32'h11)) begin errors++; $display("FAIL fwd_wb: got %h want %h", bus.d0, FWD ? 32'hBB : 32'h11); end
    bus.rs1_addr = 5'd0; exm_reg_write = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
    tick();
    checks++;
    if (bus.d0 !== 32'h11) begin errors++; $display("FAIL fwd_x0: got %h want 11", bus.d0); end
    idle_inputs();
    bus.in_valid = 1'b1; bus.rs2_addr = 5'd6; bus.rs2_data = 32'h60; bus.alu_src = 1'b0;
    wb_reg_write = 1'b1; wb_rd = 5'd6; wb_result = 32'h66;
    tick();
    checks++;
    if (bus.d1 !== (FWD ? 32'h66 : 32'h60)) begin errors++; $display("FAIL fwd_rs2_wb: got %h want %h", bus.d1, FWD ? 32'h66 : 32'h60); end
    idle_inputs();
    tick();
  endtask

  task automatic test_hold();
    idle_inputs();
    bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.alu_src = 1'b0;
    bus.rs2_addr = 5'd7; bus.rs2_data = 32'h10; bus.alu_ctrl_in = 3'b010;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b want 0", bus.in_ready); end
    exm_reg_write = 1'b1; exm_rd = 5'd7; exm_result = 32'h42; bus.rs2_data = 32'h99;
    tick();
    checks++;
    if (bus.d1 !== (FWD ? 32'h42 : 32'h10)) begin errors++; $display("FAIL hold_refresh_d1: got %h want %h", bus.d1, FWD ? 32'h42 : 32'h10); end
    exm_reg_write = 1'b0;
    tick();
    checks++;
    if (bus.d1 !== (FWD ? 32'h42 : 32'h10) || bus.ALUctrl !== 3'b010 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_stable: got d1=%h ctrl=%b v=%b want d1=%h ctrl=010 v=1",
                         bus.d1, bus.ALUctrl, bus.out_valid, FWD ? 32'h42 : 32'h10);
    end
    // held instruction with immediate: rs2 match must not touch d1, rs1 match refreshes d0
    idle_inputs();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.alu_src = 1'b1; bus.imm = 32'h77;
    bus.rs1_addr = 5'd9; bus.rs1_data = 32'h19; bus.rs2_addr = 5'd8;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    exm_reg_write = 1'b1; exm_rd = 5'd8; exm_result = 32'h55;
    wb_reg_write = 1'b1; wb_rd = 5'd9; wb_result = 32'h66;
    tick();
    checks++;
    if (bus.d1 !== 32'h77) begin errors++; $display("FAIL hold_imm_kept: got %h want 77", bus.d1); end
    checks++;
    if (bus.d0 !== (FWD ? 32'h66 : 32'h19)) begin errors++; $display("FAIL hold_refresh_d0: got %h want %h", bus.d0, FWD ? 32'h66 : 32'h19); end
    idle_inputs();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    bus.in_valid = 1'b1; bus.rs1_data = 32'hA1; bus.alu_src = 1'b1; bus.imm = 32'h1;
    tick();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
    bus.rs1_data = 32'hB2;
    tick();
    checks++;
    if (bus.d0 !== 32'hB2 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_replace: got d0=%h v=%b want d0=b2 v=1", bus.d0, bus.out_valid);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    bus.in_valid = 1'b1; bus.rs1_data = 32'h21; bus.rd_addr = 5'd2; bus.reg_write_in = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.out_ready = 1'b1; flush = 1'b1;
    bus.rs1_data = 32'h33; bus.rd_addr = 5'd5;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.reg_write_out !== 1'b0) begin
      errors++; $display("FAIL flush_ctrl: got v=%b rw=%b want 0 0", bus.out_valid, bus.reg_write_out);
    end
    checks++;
    if (bus.d0 !== 32'h21 || bus.rd_out !== 5'd2) begin
      errors++; $display("FAIL flush_data_kept: got d0=%h rd=%0d want d0=21 rd=2", bus.d0, bus.rd_out);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_alu_ctrl();
    logic [2:0] exp_tab [8];
    exp_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000, 3'b101, 3'b000, 3'b000};
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.alu_ctrl_in = 3'(i);
      tick();
      checks++;
      if (bus.ALUctrl !== exp_tab[i]) begin
        errors++; $display("FAIL alu_code_%0d: got %b want %b", i, bus.ALUctrl, exp_tab[i]);
      end
    end
    bus.rd_addr = 5'd0; bus.reg_write_in = 1'b1;
    tick();
    checks++;
    if (bus.reg_write_out !== 1'b0) begin errors++; $display("FAIL rd0_no_write: got %b want 0", bus.reg_write_out); end
    bus.rd_addr = 5'd12;
    tick();
    checks++;
    if (bus.reg_write_out !== 1'b1) begin errors++; $display("FAIL rd12_write: got %b want 1", bus.reg_write_out); end
    idle_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    test_reset();
    test_accept();
    test_forward();
    test_hold();
    test_back_to_back();
    test_flush();
    test_alu_ctrl();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
